// File: rtl/dmem_pkg.sv
// Shared types and constants for the per-node data-memory responder.
package dmem_pkg;

  localparam int DMEM_DATA_WIDTH    = 64;
  localparam int DMEM_DEFAULT_DEPTH = 256;

  typedef logic [DMEM_DATA_WIDTH-1:0] word_t;

  typedef enum logic {
    INIT,
    READY
  } state_e;

  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, registered synchronous read.
module dmem_array #(
  parameter  int DW    = 64,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  // NOTE: storage and its read register have no reset so the array maps onto
  // block RAM; the responder clears contents with a sweep and masks r_q.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/node_dmem_responder.sv
// Memory end of one core's DMEM port: zero-fill sweep after reset, then one
// read or write per cycle with 1-cycle read latency. Define DMEM_STATS_EN to
// build the saturating rd_count/wr_count counters (tied to 0 otherwise).
module node_dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = DMEM_DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_en,
  input  logic                  mem_wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  init_done,
  output logic                  oob_err,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DEPTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_rd_valid;
  logic             r_rd_zero;
  logic             r_oob;

  logic                  w_init;
  logic                  w_accept;
  logic                  w_oob;
  logic                  w_wr_ok;
  logic                  w_rd;
  logic                  w_rd_ok;
  logic                  w_ram_we;
  logic [IDX_W-1:0]      w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [DATA_WIDTH-1:0] w_ram_q;

  // Full-width compare so out-of-range addresses never alias into the array.
  assign w_init   = (r_state == INIT);
  assign w_accept = ~w_init & mem_en;
  assign w_oob    = (addr >= DEPTH_A);
  assign w_wr_ok  = w_accept & mem_wr_en & ~w_oob;
  assign w_rd     = w_accept & ~mem_wr_en;
  assign w_rd_ok  = w_rd & ~w_oob;

  assign w_ram_we    = w_init ? 1'b1  : w_wr_ok;
  assign w_ram_addr  = w_init ? r_idx : addr[IDX_W-1:0];
  assign w_ram_wdata = w_init ? '0    : wr_data;

  dmem_array #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_rd_ok),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_init) r_idx <= r_idx + 1'b1;
    end
  end

  // NOTE: the default assignment first keeps this combinational block
  // latch-free for any state encoding.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (r_idx == LAST_IDX) w_state_nxt = READY;
      READY:   w_state_nxt = READY;
      default: w_state_nxt = INIT;
    endcase
  end

  // r_rd_zero masks the unreset RAM read register after reset and forces 0
  // for out-of-range reads; it only changes on a read so rd_data holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_zero  <= 1'b1;
      r_oob      <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) r_rd_zero <= w_oob;
      if (w_accept && w_oob) r_oob <= 1'b1;
    end
  end

  assign rd_data   = r_rd_zero ? '0 : w_ram_q;
  assign rd_valid  = r_rd_valid;
  assign init_done = (r_state == READY);
  assign oob_err   = r_oob;

`ifdef DMEM_STATS_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rd && r_rd_count != CNT_SAT) r_rd_count <= r_rd_count + 1'b1;
      if (w_accept && mem_wr_en && r_wr_count != CNT_SAT)
        r_wr_count <= r_wr_count + 1'b1;
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_node_dmem_responder.sv
// Directed self-checking bench for node_dmem_responder (default parameters).
module tb_node_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en;
  logic        mem_wr_en;
  logic [31:0] addr;
  word_t       wr_data;
  word_t       rd_data;
  logic        rd_valid;
  logic        init_done;
  logic        oob_err;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  node_dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .mem_en    (mem_en),
    .mem_wr_en (mem_wr_en),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .init_done (init_done),
    .oob_err   (oob_err),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt(input logic [31:0] n);
`ifdef DMEM_STATS_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  // Operation tasks are entered at a negedge, drive for one cycle and return
  // at the next negedge, where the result of a read is visible.
  task automatic op_wr(input logic [31:0] a, input word_t d);
    mem_en = 1'b1; mem_wr_en = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
  endtask

  task automatic op_rd(input logic [31:0] a);
    mem_en = 1'b1; mem_wr_en = 1'b0; addr = a; wr_data = '0;
    @(negedge clk);
  endtask

  task automatic op_idle();
    mem_en = 1'b0; mem_wr_en = 1'b0; addr = '0; wr_data = '0;
    @(negedge clk);
  endtask

  task automatic expect_rd(input string name, input word_t d);
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== d) begin
      n_bad++;
      $display("FAIL %s: rd_valid=%b rd_data=%h, expected rd_valid=1 rd_data=%h",
               name, rd_valid, rd_data, d);
    end
  endtask

  // Counts posedges until init_done rises, checking rd outputs stay idle.
  task automatic count_init(input string name);
    int  n;
    logic quiet;
    n = 0;
    quiet = 1'b1;
    while (n < 400 && init_done !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (rd_valid !== 1'b0 || rd_data !== '0) quiet = 1'b0;
    end
    n_cmp++;
    if (n != 256) begin
      n_bad++;
      $display("FAIL %s_latency: init_done after %0d cycles, expected 256", name, n);
    end
    n_cmp++;
    if (quiet !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_quiet: rd_valid/rd_data active during init, expected 0", name);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || init_done !== 1'b0 || oob_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: rd_data=%h rd_valid=%b init_done=%b oob_err=%b, expected all 0",
               rd_data, rd_valid, init_done, oob_err);
    end
    n_cmp++;
    if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_counts: rd_count=%0d wr_count=%0d, expected 0 0", rd_count, wr_count);
    end
    reset = 1'b0;
    count_init("init");
  endtask

  task automatic test_basic();
    op_wr(32'd5, 64'hDEAD_BEEF_CAFE_F00D);
    op_rd(32'd5);
    expect_rd("raw_addr5", 64'hDEAD_BEEF_CAFE_F00D);
    op_idle();
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== 64'hDEAD_BEEF_CAFE_F00D) begin
      n_bad++;
      $display("FAIL hold: rd_valid=%b rd_data=%h, expected rd_valid=0 rd_data=deadbeefcafef00d",
               rd_valid, rd_data);
    end
  endtask

  task automatic test_unwritten_noop();
    op_rd(32'd7);
    expect_rd("unwritten_addr7", 64'h0);
    mem_en = 1'b0; mem_wr_en = 1'b1; addr = 32'd9; wr_data = 64'h1;
    @(negedge clk);
    op_rd(32'd5);
    expect_rd("reread_addr5", 64'hDEAD_BEEF_CAFE_F00D);
    op_rd(32'd9);
    expect_rd("noop_addr9", 64'h0);
    op_idle();
  endtask

  task automatic test_oob();
    n_cmp++;
    if (oob_err !== 1'b0) begin
      n_bad++;
      $display("FAIL oob_pre: oob_err=%b, expected 0", oob_err);
    end
    op_wr(32'd300, 64'h1);
    op_idle();
    n_cmp++;
    if (oob_err !== 1'b1) begin
      n_bad++;
      $display("FAIL oob_write: oob_err=%b, expected 1", oob_err);
    end
    op_rd(32'd44);
    expect_rd("no_alias_addr44", 64'h0);
    op_rd(32'd5);
    expect_rd("addr5_before_oob", 64'hDEAD_BEEF_CAFE_F00D);
    op_rd(32'd300);
    expect_rd("oob_read", 64'h0);
    op_rd(32'h8000_0005);
    expect_rd("oob_high_bit", 64'h0);
    op_idle();
    n_cmp++;
    if (oob_err !== 1'b1) begin
      n_bad++;
      $display("FAIL oob_sticky: oob_err=%b, expected 1", oob_err);
    end
  endtask

  task automatic test_back_to_back();
    op_wr(32'd1, 64'd10);
    op_wr(32'd2, 64'd20);
    op_wr(32'd3, 64'd30);
    op_rd(32'd1);
    expect_rd("b2b_1", 64'd10);
    op_rd(32'd2);
    expect_rd("b2b_2", 64'd20);
    op_rd(32'd3);
    expect_rd("b2b_3", 64'd30);
    op_rd(32'd255);
    expect_rd("b2b_last_word", 64'd0);
    op_idle();
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: rd_valid=%b, expected 0", rd_valid);
    end
  endtask

  task automatic test_reset_mid_init();
    logic quiet;
    // Counters and oob_err are non-zero here; reset must clear them.
    reset = 1'b1;
    #1;
    n_cmp++;
    if (init_done !== 1'b0 || oob_err !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0) begin
      n_bad++;
      $display("FAIL reset_ready: init_done=%b oob_err=%b rd_valid=%b rd_data=%h, expected 0",
               init_done, oob_err, rd_valid, rd_data);
    end
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 100; i++) begin
      mem_en = 1'b1; mem_wr_en = i[0]; addr = 32'd4; wr_data = 64'hFF;
      @(posedge clk); #1;
      if (rd_valid !== 1'b0 || init_done !== 1'b0) quiet = 1'b1 & 1'b0;
    end
    n_cmp++;
    if (quiet !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_in_init: request served before init_done, expected ignored");
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (init_done !== 1'b0 || rd_count !== 32'd0 || wr_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid_init: init_done=%b rd_count=%0d wr_count=%0d, expected 0 0 0",
               init_done, rd_count, wr_count);
    end
    mem_en = 1'b0; mem_wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    fork
      count_init("reinit");
      begin
        // Late in the sweep (index past 2) a write to addr 2 must still be ignored.
        repeat (200) @(negedge clk);
        mem_en = 1'b1; mem_wr_en = 1'b1; addr = 32'd2; wr_data = 64'hFF;
        repeat (50) @(negedge clk);
        mem_en = 1'b0; mem_wr_en = 1'b0;
      end
    join
  endtask

  task automatic test_stats();
    op_wr(32'd10, 64'hA);
    op_wr(32'd11, 64'hB);
    op_wr(32'd400, 64'hC);
    op_rd(32'd10);
    expect_rd("stats_rd10", 64'hA);
    op_rd(32'd11);
    expect_rd("stats_rd11", 64'hB);
    op_idle();
    n_cmp++;
    if (wr_count !== exp_cnt(32'd3) || rd_count !== exp_cnt(32'd2)) begin
      n_bad++;
      $display("FAIL stats: wr_count=%0d rd_count=%0d, expected %0d %0d",
               wr_count, rd_count, exp_cnt(32'd3), exp_cnt(32'd2));
    end
    op_rd(32'd2);
    expect_rd("init_write_ignored", 64'h0);
    op_idle();
  endtask

  initial begin
    reset = 1'b1; mem_en = 1'b0; mem_wr_en = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_unwritten_noop();
    test_oob();
    test_back_to_back();
    test_reset_mid_init();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
